imem_fetch_responder: RTL and testbench
=======================================

Name: imem_fetch_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface.
- Accepts 16-bit word addresses from the program-counter/fetch side and returns the instruction after a fixed pipelined latency.
- Buffers returned instructions in a small output queue. Supports a redirect flush that discards all in-flight and queued fetches when a branch is taken.
- Contains an internal word-addressed instruction store with a load/write port.

Parameters:
- DEPTH, 256: number of 16-bit instruction words in the store; legal addresses are 0..DEPTH-1.
- LATENCY, 2: cycles from request acceptance to the entry becoming visible in the output queue; legal range 1..4.
- QDEPTH, 2: number of output queue entries; also the credit limit on outstanding fetches.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous active-high reset.
- req_valid, input, 1: fetch request present.
- req_addr, input, 16: word address to fetch.
- req_ready, output, 1: responder can accept a request this cycle.
- flush, input, 1: redirect; discard all outstanding fetches.
- rsp_valid, output, 1: output queue head is valid.
- rsp_ready, input, 1: consumer takes the head this cycle.
- rsp_instr, output, 16: instruction at the queue head.
- rsp_addr, output, 16: address that produced rsp_instr.
- rsp_oob, output, 1: head request was out of range.
- wr_en, input, 1: store write enable.
- wr_addr, input, 16: store write address.
- wr_data, input, 16: store write data.
- busy, output, 1: any fetch is in flight or queued.

Behaviour:
- Reset (async, rst=1):
  - All pipeline valid bits and queue entries are cleared; queue pointers and count return to 0.
  - Outputs: rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_oob=0, busy=0, req_ready=1.
  - Store contents are not cleared.
  - Reset mid-fetch drops every in-flight and queued entry; no response ever appears for them.
- Credit counting:
  - outstanding = in-flight pipeline entries + queue occupancy.
  - req_ready = (outstanding < QDEPTH). It depends only on registered state, never combinationally on req_valid or rsp_ready.
  - A queue pop in the current cycle does not raise req_ready in that same cycle.
- Acceptance:
  - A request is accepted when req_valid && req_ready.
  - The store is read at acceptance, capturing data, address and out-of-range status into pipeline stage 1.
  - The entry shifts one stage per cycle with no stalls; credits guarantee queue space.
  - After LATENCY edges it is pushed into the queue. With an empty queue, rsp_valid rises exactly LATENCY cycles after the accept edge.
- Ordering: responses return strictly in acceptance order.
- Out of range (req_addr >= DEPTH): rsp_instr=16'hF000 (HLT encoding) and rsp_oob=1; no store access.
- Write/read collision:
  - A write to the same address in the acceptance cycle is not visible; the fetch returns the old word.
  - The write is visible to fetches accepted on later cycles.
  - Writes with wr_addr >= DEPTH are ignored.
- Output queue:
  - Head is popped when rsp_valid && rsp_ready.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo QDEPTH.
  - When the queue is empty, rsp_instr, rsp_addr and rsp_oob hold their last values; rsp_valid=0.
- Flush (edge-sampled):
  - Clears all pipeline valid bits and empties the queue.
  - A pop in the same cycle is ignored.
  - A request accepted in the flush cycle is the redirect target: it survives and enters stage 1. req_ready is evaluated on pre-flush state.
  - Flush with nothing outstanding has no effect.
- busy = (outstanding != 0).

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - The store keeps one even-parity bit per word, written on wr_en.
  - Extra output rsp_perr (1 bit) is queued alongside each entry; it is 1 when the stored parity mismatches the data read.
  - Out-of-range entries give rsp_perr=0.
  - rsp_perr resets to 0.
- Undefined: no parity storage and no rsp_perr port.

Test Plan:
- Basic latency: LATENCY=2. Write 0x1234 at addr 5, then request addr 5 at edge N with rsp_ready=1 → rsp_valid=1 after edge N+2 with rsp_instr=0x1234 and rsp_addr=5; busy=0 after the pop.
- Credit backpressure: QDEPTH=2, rsp_ready=0. Issue requests to addrs 0,1,2 back-to-back → only 0 and 1 are accepted and req_ready=0 afterwards. Raise rsp_ready for one cycle → req_ready=1 on the following cycle and addr 2 is accepted. Responses return in order 0,1,2.
- Flush with redirect: two fetches in flight, then flush together with a request to addr 9 → the old fetches never appear; the only response is addr 9, LATENCY cycles later.
- Out of range: request addr 16'h0100 with DEPTH=256 → rsp_instr=16'hF000, rsp_oob=1.
- Collision: wr_en to addr 3 with 0xBEEF in the same cycle as accepting a fetch of addr 3 (old value 0x0001) → returns 0x0001; the next fetch of addr 3 returns 0xBEEF.
- Async reset mid-flight: assert rst between clock edges with 2 entries outstanding → rsp_valid=0, busy=0 and req_ready=1 immediately. No response appears after rst is released.

Source files
------------

// File: rtl/imem_fetch_responder_if.sv
// Fetch-side bus between the PC/fetch logic and imem_fetch_responder.
// rsp_perr is present only when IMEM_PARITY_EN is defined.
interface imem_fetch_responder_if;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_instr;
    logic [15:0] rsp_addr;
    logic        rsp_oob;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
`ifdef IMEM_PARITY_EN
    logic        rsp_perr;
`endif

    modport master (
        output req_valid, req_addr, flush, rsp_ready,
        output wr_en, wr_addr, wr_data,
`ifdef IMEM_PARITY_EN
        input  rsp_perr,
`endif
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_oob, busy
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready,
        input  wr_en, wr_addr, wr_data,
`ifdef IMEM_PARITY_EN
        output rsp_perr,
`endif
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_oob, busy
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction store with fixed-latency fetch pipeline and credited output queue.
// Define IMEM_PARITY_EN to add per-word even parity and the rsp_perr output.
module imem_fetch_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 2
) (
    input logic                   clk,
    input logic                   rst,
    imem_fetch_responder_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + LATENCY + 1);

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] addr;
        logic        oob;
`ifdef IMEM_PARITY_EN
        logic        perr;
`endif
    } ent_t;

    logic [15:0] mem [DEPTH];
`ifdef IMEM_PARITY_EN
    logic        par [DEPTH];
`endif

    ent_t             pipe [LATENCY];
    logic [LATENCY-1:0] pv;
    ent_t             q [QDEPTH];
    logic [QW-1:0]    wr_ptr;
    logic [QW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    ent_t             hold;
    ent_t             head;
    ent_t             rd_ent;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    outstanding;
    logic             accept;
    logic             push;
    logic             pop;
    logic             in_range;
    logic             wr_ok;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    wr_idx;

    function automatic logic [QW-1:0] inc(input logic [QW-1:0] p);
        return (p == QW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_idx   = bus.req_addr[AW-1:0];
    assign wr_idx   = bus.wr_addr[AW-1:0];
    assign in_range = {1'b0, bus.req_addr} < 17'(DEPTH);
    assign wr_ok    = bus.wr_en && ({1'b0, bus.wr_addr} < 17'(DEPTH));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++)
            inflight = inflight + CW'(pv[i]);
    end

    // Credits cover both stages and queue, so a push never finds it full.
    assign outstanding   = inflight + count;
    assign bus.req_ready = outstanding < CW'(QDEPTH);
    assign bus.busy      = outstanding != '0;
    assign accept        = bus.req_valid && bus.req_ready;
    assign push          = pv[LATENCY-1] && !bus.flush;
    assign pop           = (count != '0) && bus.rsp_ready && !bus.flush;

    always_comb begin
        rd_ent       = '0;
        rd_ent.addr  = bus.req_addr;
        rd_ent.oob   = !in_range;
        rd_ent.instr = in_range ? mem[rd_idx] : 16'hF000;
`ifdef IMEM_PARITY_EN
        rd_ent.perr  = in_range && (^{par[rd_idx], mem[rd_idx]});
`endif
    end

    assign head          = (count != '0) ? q[rd_ptr] : hold;
    assign bus.rsp_valid = count != '0;
    assign bus.rsp_instr = head.instr;
    assign bus.rsp_addr  = head.addr;
    assign bus.rsp_oob   = head.oob;
`ifdef IMEM_PARITY_EN
    assign bus.rsp_perr  = head.perr;
`endif

    // Read above uses the pre-edge word, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= bus.wr_data;
`ifdef IMEM_PARITY_EN
            par[wr_idx] <= ^bus.wr_data;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
            for (int i = 0; i < LATENCY; i++)
                pipe[i] <= '0;
            for (int i = 0; i < QDEPTH; i++)
                q[i] <= '0;
        end else begin
            hold    <= head;
            pipe[0] <= rd_ent;
            pv[0]   <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
                pv[i]   <= pv[i-1] && !bus.flush;
            end
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    q[wr_ptr] <= pipe[LATENCY-1];
                    wr_ptr    <= inc(wr_ptr);
                end
                if (pop)
                    rd_ptr <= inc(rd_ptr);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder (DEPTH=256, LATENCY=2, QDEPTH=2).
// Expected words come from a bench-side copy of every store write.
module tb_imem_fetch_responder;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] addr;
        logic        oob;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_fetch_responder_if bus ();

    imem_fetch_responder #(
        .DEPTH(256), .LATENCY(2), .QDEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [15:0] model_mem [256];
    rsp_t        sb [$];
    rsp_t        got_arr [1024];
    int          got_n = 0;
    int          got_rd = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    rsp_t        o;
    rsp_t        e;
    int          cyc;

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            got_arr[got_n % 1024] <= {bus.rsp_instr, bus.rsp_addr, bus.rsp_oob};
            got_n <= got_n + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: still running at 200000, required finish");
        $fatal(1, "watchdog");
    end

    function automatic rsp_t mk(input logic [15:0] a);
        rsp_t r;
        r.addr  = a;
        r.oob   = (a >= 16'd256);
        r.instr = r.oob ? 16'hF000 : model_mem[a[7:0]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] a, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
        if (a < 16'd256) model_mem[a[7:0]] = d;
    endtask

    task automatic issue(input logic [15:0] a);
        int c;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        c = 0;
        @(negedge clk);
        while (!bus.req_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        sb.push_back(mk(a));
        tick();
    endtask

    task automatic settle();
        for (int c = 0; c < 40 && bus.busy; c++) tick();
        tick();
    endtask

    task automatic measure_latency();
        cyc = 0;
        @(negedge clk);
        while (!bus.rsp_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ctrl: valid=%b busy=%b ready=%b, required 0 0 1",
                     bus.rsp_valid, bus.busy, bus.req_ready);
        end
        n_cmp++;
        if (bus.rsp_instr !== 16'h0 || bus.rsp_addr !== 16'h0 || bus.rsp_oob !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_data: instr=%h addr=%h oob=%b, required 0 0 0",
                     bus.rsp_instr, bus.rsp_addr, bus.rsp_oob);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) write_word(16'(i), 16'hA000 + 16'(i));
        write_word(16'd3, 16'h0001);
        write_word(16'd255, 16'h55AA);
    endtask

    task automatic test_basic_latency();
        write_word(16'd5, 16'h1234);
        write_word(16'h0105, 16'hDEAD);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'd5;
        sb.push_back(mk(16'd5));
        tick();
        bus.req_valid = 1'b0;
        measure_latency();
        n_cmp++;
        if (cyc !== 2) begin
            n_bad++;
            $display("FAIL basic_latency: %0d cycles, required 2", cyc);
        end
        n_cmp++;
        if (bus.rsp_instr !== 16'h1234 || bus.rsp_addr !== 16'd5) begin
            n_bad++;
            $display("FAIL basic_head: instr=%h addr=%h, required 1234 0005",
                     bus.rsp_instr, bus.rsp_addr);
        end
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_idle: busy=%b valid=%b, required 0 0", bus.busy, bus.rsp_valid);
        end
        n_cmp++;
        if (bus.rsp_instr !== 16'h1234) begin
            n_bad++;
            $display("FAIL basic_hold: instr=%h, required 1234", bus.rsp_instr);
        end
        settle();
        while (got_rd < got_n) begin
            o = got_arr[got_rd % 1024]; got_rd++; n_cmp++;
            if (sb.size() == 0) begin
                n_bad++; $display("FAIL basic_extra: got %h, required none", o);
            end else begin
                e = sb.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL basic_rsp: got %h, required %h", o, e); end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL basic_missing: %0d left, required 0", sb.size()); sb.delete();
        end
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'd0;
        sb.push_back(mk(16'd0));
        tick();
        bus.req_addr = 16'd1;
        sb.push_back(mk(16'd1));
        tick();
        bus.req_addr = 16'd2;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_full: ready=%b, required 0", bus.req_ready);
        end
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_hold: ready=%b valid=%b, required 0 1", bus.req_ready, bus.rsp_valid);
        end
        tick();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_same_cycle: ready=%b, required 0", bus.req_ready);
        end
        tick();
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release: ready=%b, required 1", bus.req_ready);
        end
        sb.push_back(mk(16'd2));
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_refill: ready=%b, required 0", bus.req_ready);
        end
        bus.rsp_ready = 1'b1;
        settle();
        while (got_rd < got_n) begin
            o = got_arr[got_rd % 1024]; got_rd++; n_cmp++;
            if (sb.size() == 0) begin
                n_bad++; $display("FAIL bp_extra: got %h, required none", o);
            end else begin
                e = sb.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL bp_rsp: got %h, required %h", o, e); end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL bp_missing: %0d left, required 0", sb.size()); sb.delete();
        end
    endtask

    task automatic test_flush();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'd7;
        tick();
        bus.req_addr = 16'd8;
        tick();
        bus.flush    = 1'b1;
        bus.req_addr = 16'd9;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_bad++; $display("FAIL flush_pre_ready: ready=%b, required 0", bus.req_ready);
        end
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_clear: busy=%b ready=%b, required 0 1", bus.busy, bus.req_ready);
        end
        sb.push_back(mk(16'd9));
        tick();
        bus.req_valid = 1'b0;
        measure_latency();
        n_cmp++;
        if (cyc !== 2) begin
            n_bad++; $display("FAIL flush_a_latency: %0d cycles, required 2", cyc);
        end
        settle();
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'd10;
        tick();
        bus.flush    = 1'b1;
        bus.req_addr = 16'd11;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush_redirect_ready: ready=%b, required 1", bus.req_ready);
        end
        sb.push_back(mk(16'd11));
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        measure_latency();
        n_cmp++;
        if (cyc !== 2) begin
            n_bad++; $display("FAIL flush_b_latency: %0d cycles, required 2", cyc);
        end
        settle();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_addr !== 16'd11) begin
            n_bad++;
            $display("FAIL flush_idle: valid=%b busy=%b addr=%h, required 0 0 000b",
                     bus.rsp_valid, bus.busy, bus.rsp_addr);
        end
        tick();
        while (got_rd < got_n) begin
            o = got_arr[got_rd % 1024]; got_rd++; n_cmp++;
            if (sb.size() == 0) begin
                n_bad++; $display("FAIL flush_extra: got %h, required none", o);
            end else begin
                e = sb.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL flush_rsp: got %h, required %h", o, e); end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL flush_missing: %0d left, required 0", sb.size()); sb.delete();
        end
    endtask

    task automatic test_oob();
        bus.rsp_ready = 1'b1;
        issue(16'h00FF);
        issue(16'h0100);
        issue(16'hFFFF);
        bus.req_valid = 1'b0;
        settle();
        n_cmp++;
        if (bus.rsp_instr !== 16'hF000 || bus.rsp_oob !== 1'b1 || bus.rsp_addr !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL oob_hold: instr=%h oob=%b addr=%h, required f000 1 ffff",
                     bus.rsp_instr, bus.rsp_oob, bus.rsp_addr);
        end
        while (got_rd < got_n) begin
            o = got_arr[got_rd % 1024]; got_rd++; n_cmp++;
            if (sb.size() == 0) begin
                n_bad++; $display("FAIL oob_extra: got %h, required none", o);
            end else begin
                e = sb.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL oob_rsp: got %h, required %h", o, e); end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL oob_missing: %0d left, required 0", sb.size()); sb.delete();
        end
    endtask

    task automatic test_collision();
        bus.rsp_ready = 1'b1;
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 16'd3;
        bus.wr_data   = 16'hBEEF;
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'd3;
        sb.push_back(mk(16'd3));
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL coll_ready: ready=%b, required 1", bus.req_ready);
        end
        tick();
        bus.wr_en = 1'b0;
        model_mem[3] = 16'hBEEF;
        issue(16'd3);
        bus.req_valid = 1'b0;
        settle();
        n_cmp++;
        if (bus.rsp_instr !== 16'hBEEF) begin
            n_bad++; $display("FAIL coll_last: instr=%h, required beef", bus.rsp_instr);
        end
        while (got_rd < got_n) begin
            o = got_arr[got_rd % 1024]; got_rd++; n_cmp++;
            if (sb.size() == 0) begin
                n_bad++; $display("FAIL coll_extra: got %h, required none", o);
            end else begin
                e = sb.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL coll_rsp: got %h, required %h", o, e); end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL coll_missing: %0d left, required 0", sb.size()); sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) issue(16'($urandom_range(0, 15)));
        bus.req_valid = 1'b0;
        settle();
        while (got_rd < got_n) begin
            o = got_arr[got_rd % 1024]; got_rd++; n_cmp++;
            if (sb.size() == 0) begin
                n_bad++; $display("FAIL b2b_extra: got %h, required none", o);
            end else begin
                e = sb.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL b2b_rsp: got %h, required %h", o, e); end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL b2b_missing: %0d left, required 0", sb.size()); sb.delete();
        end
    endtask

    task automatic test_async_reset();
        int seen;
        bus.rsp_ready = 1'b0;
        issue(16'd4);
        issue(16'd6);
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL arst_pre: busy=%b, required 1", bus.busy);
        end
        #3;
        rst = 1'b1;
        sb.delete();
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_now: valid=%b busy=%b ready=%b, required 0 0 1",
                     bus.rsp_valid, bus.busy, bus.req_ready);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++; $display("FAIL arst_ghost: %0d valid cycles, required 0", seen);
        end
        tick();
        issue(16'd5);
        bus.req_valid = 1'b0;
        settle();
        while (got_rd < got_n) begin
            o = got_arr[got_rd % 1024]; got_rd++; n_cmp++;
            if (sb.size() == 0) begin
                n_bad++; $display("FAIL arst_extra: got %h, required none", o);
            end else begin
                e = sb.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL arst_rsp: got %h, required %h", o, e); end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL arst_missing: %0d left, required 0", sb.size()); sb.delete();
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        test_reset();
        preload();
        test_basic_latency();
        test_backpressure();
        test_flush();
        test_oob();
        test_collision();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
